ps2_rx_ctrl: RTL and testbench

PS2_RX_CTRL -- requirements
Module: ps2_rx_ctrl

---
 rtl/ps2_rx_ctrl.sv | 154 +++++++++++++++
 tb/tb_ps2_rx_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_ctrl.sv
// PS/2 device-to-host receiver: synchronise and filter the PS/2 lines,
// deframe 11-bit frames, hold one byte for the consumer, flag errors.
module ps2_rx_ctrl #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 100_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] code,
   output logic       code_valid,
   input  logic       code_ack,
   output logic       parity_err,
   output logic       frame_err,
   output logic       overrun,
   output logic       busy
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [FW-1:0] FL_MAX = FW'(FILTER_LEN - 1);
   localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t        state, state_n;
   logic [1:0]    csync, dsync;
   logic          sclk, sdat;
   logic [FW-1:0] fcnt;
   logic          fclk, fclk_d, fall;
   logic [TW-1:0] tocnt;
   logic          to_hit;
   logic [2:0]    bcnt, bcnt_n;
   logic [7:0]    shreg, shreg_n;
   logic          par, par_n;
   logic          good, perr_n, ferr_n;
   logic          ack_eff;

   assign sclk    = csync[1];
   assign sdat    = dsync[1];
   assign fall    = fclk_d & ~fclk;
   assign to_hit  = (state != IDLE) && !fall && (tocnt == TO_MAX);
   assign ack_eff = code_ack & code_valid;
   assign busy    = (state != IDLE);

   // Filtered clock only follows after FILTER_LEN agreeing samples
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         csync  <= 2'b11;
         dsync  <= 2'b11;
         fcnt   <= '0;
         fclk   <= 1'b1;
         fclk_d <= 1'b1;
      end else begin
         csync  <= {csync[0], ps2_clk};
         dsync  <= {dsync[0], ps2_data};
         fclk_d <= fclk;
         if (sclk == fclk) begin
            fcnt <= '0;
         end else if (fcnt == FL_MAX) begin
            fclk <= sclk;
            fcnt <= '0;
         end else begin
            fcnt <= fcnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         bcnt  <= '0;
         shreg <= '0;
         par   <= 1'b0;
         tocnt <= '0;
      end else begin
         state <= state_n;
         bcnt  <= bcnt_n;
         shreg <= shreg_n;
         par   <= par_n;
         if (state == IDLE || fall)
            tocnt <= '0;
         else if (!to_hit)
            tocnt <= tocnt + 1'b1;
      end
   end

   always_comb begin
      state_n = state;
      bcnt_n  = bcnt;
      shreg_n = shreg;
      par_n   = par;
      good    = 1'b0;
      perr_n  = 1'b0;
      ferr_n  = 1'b0;
      if (fall) begin
         unique case (state)
            IDLE: begin
               if (!sdat) begin
                  state_n = DATA;
                  bcnt_n  = '0;
                  shreg_n = '0;
               end
            end
            DATA: begin
               shreg_n[bcnt] = sdat;
               bcnt_n = bcnt + 3'd1;
               if (bcnt == 3'd7)
                  state_n = PARITY;
            end
            PARITY: begin
               par_n   = sdat;
               state_n = STOP;
            end
            STOP: begin
               state_n = IDLE;
               // Stop-bit error masks any parity error
               if (!sdat)
                  ferr_n = 1'b1;
               else if (!(^{shreg, par}))
                  perr_n = 1'b1;
               else
                  good = 1'b1;
            end
            default: state_n = IDLE;
         endcase
      end else if (to_hit) begin
         state_n = IDLE;
         ferr_n  = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         code       <= 8'h00;
         code_valid <= 1'b0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         parity_err <= perr_n;
         frame_err  <= ferr_n;
         overrun    <= good & code_valid & ~code_ack;
         if (good && (!code_valid || ack_eff)) begin
            code       <= shreg;
            code_valid <= 1'b1;
         end else if (ack_eff) begin
            code_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// Directed bench for ps2_rx_ctrl: hand-built PS/2 frames with
// expected outputs sampled at the cycle after the stop-bit fall.
module tb_ps2_rx_ctrl;

   localparam int FL = 8;
   localparam int TO = 300;
   localparam int H  = 40;

   logic       clk = 0;
   logic       rst = 1;
   logic       ps2_clk = 1;
   logic       ps2_data = 1;
   logic       code_ack = 0;
   logic [7:0] code;
   logic       code_valid;
   logic       parity_err;
   logic       frame_err;
   logic       overrun;
   logic       busy;

   int nvec = 0;
   int nbad = 0;

   logic [7:0] o_code;
   logic       o_cv, o_pe, o_fe, o_ov, o_cvpre, o_sum2;

   ps2_rx_ctrl #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
      .clk        (clk),
      .rst        (rst),
      .ps2_clk    (ps2_clk),
      .ps2_data   (ps2_data),
      .code       (code),
      .code_valid (code_valid),
      .code_ack   (code_ack),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      @(negedge clk);
      ps2_data = b;
      repeat (H/2) @(negedge clk);
      ps2_clk = 0;
      repeat (H) @(negedge clk);
      ps2_clk = 1;
      repeat (H/2) @(negedge clk);
   endtask

   // Stop fall is seen by the FSM on the 11th edge after ps2_clk drops
   task automatic send_frame(input logic [7:0] b, input logic p,
                             input logic s, input logic ack);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(p);
      @(negedge clk);
      ps2_data = s;
      repeat (H/2) @(negedge clk);
      ps2_clk = 0;
      repeat (10) @(posedge clk);
      #1;
      o_cvpre  = code_valid;
      code_ack = ack;
      @(posedge clk);
      #1;
      code_ack = 0;
      o_code = code;
      o_cv   = code_valid;
      o_pe   = parity_err;
      o_fe   = frame_err;
      o_ov   = overrun;
      @(posedge clk);
      #1;
      o_sum2 = parity_err | frame_err | overrun;
      repeat (H) @(negedge clk);
      ps2_clk = 1;
      ps2_data = 1;
      repeat (H/2) @(negedge clk);
   endtask

   task automatic do_ack;
      @(negedge clk);
      code_ack = 1;
      @(posedge clk);
      #1;
      code_ack = 0;
   endtask

   initial begin
      int n;
      logic seen;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_code", code, 8'h00);
      chk("rst_cv", code_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_pulses", {parity_err, frame_err, overrun}, 0);
      @(negedge clk);
      rst = 0;
      repeat (5) @(negedge clk);

      send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
      chk("f1c_cv_pre", o_cvpre, 0);
      chk("f1c_code", o_code, 8'h1C);
      chk("f1c_cv", o_cv, 1);
      chk("f1c_err", {o_pe, o_fe, o_ov}, 0);
      chk("f1c_busy", busy, 0);
      do_ack();
      chk("ack_cv", code_valid, 0);
      do_ack();
      chk("ack0_cv", code_valid, 0);
      chk("ack0_code", code, 8'h1C);

      send_frame(8'h1C, 1'b1, 1'b1, 1'b0);
      chk("par_pe", o_pe, 1);
      chk("par_other", {o_fe, o_ov}, 0);
      chk("par_single", o_sum2, 0);
      chk("par_code", o_code, 8'h1C);
      chk("par_cv", o_cv, 0);
      chk("par_busy", busy, 0);

      send_frame(8'h1C, 1'b1, 1'b0, 1'b0);
      chk("stop_fe", o_fe, 1);
      chk("stop_other", {o_pe, o_ov}, 0);
      chk("stop_single", o_sum2, 0);
      chk("stop_cv", o_cv, 0);

      send_frame(8'hF0, 1'b1, 1'b1, 1'b0);
      chk("ff0_code", o_code, 8'hF0);
      chk("ff0_cv", o_cv, 1);
      send_frame(8'h1C, 1'b0, 1'b1, 1'b0);
      chk("ovr_ov", o_ov, 1);
      chk("ovr_errs", {o_pe, o_fe}, 0);
      chk("ovr_code", o_code, 8'hF0);
      chk("ovr_cv", o_cv, 1);
      chk("ovr_single", o_sum2, 0);
      send_frame(8'h5A, 1'b1, 1'b1, 1'b1);
      chk("ackc_code", o_code, 8'h5A);
      chk("ackc_cv", o_cv, 1);
      chk("ackc_ov", o_ov, 0);
      do_ack();
      chk("ackc_clr", code_valid, 0);

      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      chk("to_busy", busy, 1);
      n = 0;
      seen = 0;
      while (!seen && n < TO + 200) begin
         @(posedge clk);
         #1;
         n++;
         seen = frame_err;
      end
      chk("to_seen", seen, 1);
      chk("to_window", (n >= TO - 2*H) && (n <= TO + H), 1);
      chk("to_busy0", busy, 0);
      chk("to_cv", code_valid, 0);
      @(posedge clk);
      #1;
      chk("to_single", frame_err, 0);
      send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
      chk("to5a_code", o_code, 8'h5A);
      chk("to5a_cv", o_cv, 1);
      chk("to5a_err", {o_pe, o_fe, o_ov}, 0);

      @(negedge clk);
      ps2_data = 0;
      ps2_clk = 0;
      repeat (FL - 2) @(negedge clk);
      ps2_clk = 1;
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         #1;
         seen = seen | busy | parity_err | frame_err | overrun;
      end
      chk("glitch_quiet", seen, 0);
      chk("glitch_code", {code_valid, code}, {1'b1, 8'h5A});
      @(negedge clk);
      ps2_data = 1;
      repeat (5) @(negedge clk);

      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b1);
      chk("mid_busy", busy, 1);
      @(negedge clk);
      rst = 1;
      @(posedge clk);
      #1;
      chk("mrst_code", code, 8'h00);
      chk("mrst_cv", code_valid, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_pulses", {parity_err, frame_err, overrun}, 0);
      repeat (3) @(negedge clk);
      rst = 0;
      repeat (10) @(negedge clk);
      send_frame(8'h29, 1'b0, 1'b1, 1'b0);
      chk("f29_code", o_code, 8'h29);
      chk("f29_cv", o_cv, 1);
      chk("f29_err", {o_pe, o_fe, o_ov}, 0);
      chk("f29_busy", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
